// File: rtl/word_serializer.sv
// Parallel-in, serial-out transmitter: one word in, WIDTH bits out on a valid/ready link.
// Define SER_PARITY_EN to append an even-parity bit after the data bits.
module word_serializer #(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 7,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef SER_PARITY_EN
    localparam logic [1:0] PAR   = 2'd2;
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nx;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             last;
    logic             head;
`ifdef SER_PARITY_EN
    logic             par_q;
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Zero-filled shift toward the output end of the register
    assign sreg_nx = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg[WIDTH-1:1]};
    assign head    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    assign in_ready  = (state == IDLE);
    assign ser_valid = (state != IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;

    always_comb begin
        ser_out = 1'b0;
        unique case (1'b1)
            (state == SHIFT): ser_out = head;
`ifdef SER_PARITY_EN
            (state == PAR):   ser_out = par_q;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg  <= in;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef SER_PARITY_EN
                        par_q <= ^in;
`endif
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        sreg <= sreg_nx;
                        if (last) begin
`ifdef SER_PARITY_EN
                            state  <= PAR;
`else
                            state  <= IDLE;
                            done_q <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef SER_PARITY_EN
                PAR: begin
                    if (ser_ready) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Randomized bench for word_serializer: LSB-first and MSB-first instances
// checked against a bit-queue model of the serial stream.
module tb_word_serializer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] din [2];
    logic         dv  [2];
    logic         rdy [2];
    logic         ir  [2];
    logic         so  [2];
    logic         sv  [2];
    logic         bz  [2];
    logic         dn  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    word_serializer #(.WIDTH(W), .CNT_W(7), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .in(din[0]), .in_valid(dv[0]),
        .in_ready(ir[0]), .ser_out(so[0]), .ser_valid(sv[0]),
        .ser_ready(rdy[0]), .busy(bz[0]), .done(dn[0])
    );

    word_serializer #(.WIDTH(W), .CNT_W(7), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .in(din[1]), .in_valid(dv[1]),
        .in_ready(ir[1]), .ser_out(so[1]), .ser_valid(sv[1]),
        .ser_ready(rdy[1]), .busy(bz[1]), .done(dn[1])
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode: 0 ready always, 1 ready toggling 1,0,..., 2 random ready
    // abort_at >= 0 pulls reset after that many transfers
    task automatic send(input int sel, input logic [W-1:0] w, input int mode,
                        input bit inject, input int abort_at);
        bit   q[$];
        int   nbits, j, idx, stalls, pos;
        bit   r, prev_stall;
        logic held;
        for (int i = 0; i < W; i++) begin
            pos = (sel == 1) ? (W - 1 - i) : i;
            q.push_back(bit'((w >> pos) & 1));
        end
`ifdef SER_PARITY_EN
        q.push_back(^w);
`endif
        nbits = q.size();
        @(negedge clock);
        din[sel] = w;
        dv[sel]  = 1'b1;
        rdy[sel] = 1'b0;
        check("ready_before_load", 64'(ir[sel]), 64'd1);
        @(negedge clock);
        if (inject) din[sel] = '1;
        else begin
            dv[sel]  = 1'b0;
            din[sel] = $urandom;
        end
        j = 0; idx = 0; stalls = 0; prev_stall = 1'b0; held = 1'b0;
        while (idx < nbits && j < 4 * nbits + 8) begin
            check("ser_valid_on", 64'(sv[sel]), 64'd1);
            check("busy_on", 64'(bz[sel]), 64'd1);
            check("in_ready_off", 64'(ir[sel]), 64'd0);
            check("done_early", 64'(dn[sel]), 64'd0);
            if (prev_stall) check("stall_hold", 64'(so[sel]), 64'(held));
            if (abort_at >= 0 && idx == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check("rst_ser_valid", 64'(sv[sel]), 64'd0);
                check("rst_ser_out", 64'(so[sel]), 64'd0);
                check("rst_busy", 64'(bz[sel]), 64'd0);
                check("rst_done", 64'(dn[sel]), 64'd0);
                check("rst_in_ready", 64'(ir[sel]), 64'd1);
                dv[sel]  = 1'b0;
                rdy[sel] = 1'b0;
                @(negedge clock);
                check("rst_held_done", 64'(dn[sel]), 64'd0);
                reset = 1'b1;
                return;
            end
            unique case (mode)
                0:       r = 1'b1;
                1:       r = (j % 2 == 0);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            if (r) begin
                check("bit", 64'(so[sel]), 64'(q[idx]));
                idx++;
                prev_stall = 1'b0;
            end else begin
                stalls++;
                prev_stall = 1'b1;
                held = so[sel];
            end
            rdy[sel] = r;
            @(negedge clock);
            j++;
        end
        check("all_bits_sent", 64'(idx), 64'(nbits));
        check("done_pulse", 64'(dn[sel]), 64'd1);
        check("done_in_ready", 64'(ir[sel]), 64'd1);
        check("idle_ser_valid", 64'(sv[sel]), 64'd0);
        check("idle_ser_out", 64'(so[sel]), 64'd0);
        check("idle_busy", 64'(bz[sel]), 64'd0);
        check("done_latency", 64'(j), 64'(nbits + stalls));
        dv[sel]  = 1'b0;
        rdy[sel] = 1'b0;
        @(negedge clock);
        check("done_one_cycle", 64'(dn[sel]), 64'd0);
        check("no_stray_load", 64'(bz[sel]), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            din[s] = '0;
            dv[s]  = 1'b0;
            rdy[s] = 1'b0;
        end
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            check("in_ready_in_reset", 64'(ir[s]), 64'd1);
            check("valid_in_reset", 64'(sv[s]), 64'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            check("post_rst_in_ready", 64'(ir[s]), 64'd1);
            check("post_rst_ser_valid", 64'(sv[s]), 64'd0);
            check("post_rst_busy", 64'(bz[s]), 64'd0);
            check("post_rst_done", 64'(dn[s]), 64'd0);
        end

        send(0, 32'h8000_0001, 0, 1'b0, -1);
        send(1, 32'hA5A5_A5A5, 1, 1'b0, -1);
        send(0, 32'h0000_0003, 0, 1'b1, -1);
        send(1, 32'h0000_0003, 2, 1'b1, -1);
        send(0, 32'h1234_5678, 0, 1'b0, 10);
        send(0, 32'h0000_00FF, 0, 1'b0, -1);
        send(1, 32'h1234_5678, 2, 1'b0, 5);
        send(1, 32'h0000_00FF, 0, 1'b0, -1);
        send(0, 32'h0000_0007, 0, 1'b0, -1);
        send(1, 32'h0000_0007, 1, 1'b0, -1);

        for (int k = 0; k < 8; k++)
            send(k % 2, $urandom, 2, 1'($urandom_range(0, 1)), -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
